// File: rtl/io_responder_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg : shared constants and helpers for the io_responder I/O block.
//   - IO_*_bit      : address bit that selects each device register
//                     (the device selects are one-hot in addr[7:2])
//   - KEY_RESET_VALUE : idle level of the active-low push-buttons
//   - DEBOUNCE_CYCLES_DEFAULT : default debounce length in synchronized cycles
//   - lane_pick()   : byte-lane write helper
// -----------------------------------------------------------------------------
package io_pkg;

   localparam int IO_LEDS_bit   = 2;
   localparam int IO_HEX_bit    = 3;
   localparam int IO_KEY_bit    = 4;
   localparam int IO_SW_bit     = 5;
   localparam int IO_KEYEVT_bit = 6;
   localparam int IO_TIMER_bit  = 7;

   localparam logic [3:0] KEY_RESET_VALUE = 4'hF;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

   // Returns the new byte when its lane enable is set, otherwise the old byte.
   function automatic logic [7:0] lane_pick(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       lane_en);
      logic [7:0] result;
      if (lane_en) begin
         result = new_byte;
      end else begin
         result = old_byte;
      end
      return result;
   endfunction

endpackage

// File: rtl/io_responder_if.sv
// -----------------------------------------------------------------------------
// io_bus_if : CPU data-bus view of the I/O region.
//   sel       : access targets the I/O region
//   addr      : data address, one-hot device select in [7:2]
//   writedata : store data
//   memwrite  : one-cycle store strobe
//   writemask : per-byte write enables
//   readdata  : combinational load data returned by the responder
// Modports: master (CPU side), slave (io_responder side).
// -----------------------------------------------------------------------------
interface io_bus_if;

   logic        sel;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic        memwrite;
   logic [3:0]  writemask;
   logic [31:0] readdata;

   modport master (
      output sel, addr, writedata, memwrite, writemask,
      input  readdata
   );

   modport slave (
      input  sel, addr, writedata, memwrite, writemask,
      output readdata
   );

endinterface

// File: rtl/io_responder_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce : one push-button channel.
//   clk, reset : clock and synchronous active-high reset
//   key_raw    : raw asynchronous button level (active-low)
//   key_db     : registered debounced level
//   press      : high in the cycle whose clock edge moves key_db from 1 to 0
// A 2-flop synchronizer feeds a run-length counter; key_db follows the
// synchronized level once it has differed for DEBOUNCE_CYCLES cycles.
// -----------------------------------------------------------------------------
module key_debounce
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_db,
   output logic press
);

   localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

   logic       sync1_r;
   logic       sync2_r;
   logic       db_r;
   logic [7:0] cnt_r;
   logic       db_next_s;
   logic [7:0] cnt_next_s;

   // Debounce decision: restart the run whenever the input agrees with key_db.
   always_comb begin
      db_next_s  = db_r;
      cnt_next_s = cnt_r;
      if (sync2_r == db_r) begin
         cnt_next_s = 8'd0;
      end else if (cnt_r == LAST_COUNT) begin
         db_next_s  = sync2_r;
         cnt_next_s = 8'd0;
      end else begin
         cnt_next_s = cnt_r + 8'd1;
      end
   end

   // Synchronizer, counter and debounced level registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= KEY_RESET_VALUE[0];
         sync2_r <= KEY_RESET_VALUE[0];
         db_r    <= KEY_RESET_VALUE[0];
         cnt_r   <= 8'd0;
      end else begin
         sync1_r <= key_raw;
         sync2_r <= sync1_r;
         db_r    <= db_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   assign key_db = db_r;
   // Press is asserted in the same cycle the falling update is committed.
   assign press  = db_r & ~db_next_s;

endmodule

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder : memory-mapped I/O block (LEDs, HEX display, keys, switches,
// key-press events, optional free-running timer).
//   clk, reset : clock and synchronous active-high reset
//   bus        : io_bus_if.slave CPU data bus (sel/addr/writedata/memwrite/
//                writemask in, combinational readdata out)
//   KEY        : raw active-low push-buttons, debounced per key
//   SW         : raw slide switches, synchronized
//   LEDR       : registered LED value
//   hex_digits : registered six-nibble display value
// Build option: define IO_TIMER_EN to include the 32-bit timer at 0x180;
// without it the timer reads 0 and writes to it are ignored.
// -----------------------------------------------------------------------------
module io_responder
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   io_bus_if.slave       bus,
   input  logic [3:0]    KEY,
   input  logic [9:0]    SW,
   output logic [9:0]    LEDR,
   output logic [23:0]   hex_digits
);

   logic        wr_s;
   logic [3:0]  key_db_s;
   logic [3:0]  press_s;
   logic [9:0]  sw_sync1_r;
   logic [9:0]  sw_sync2_r;
   logic [9:0]  led_r;
   logic [9:0]  led_next_s;
   logic [23:0] hex_r;
   logic [23:0] hex_next_s;
   logic [3:0]  evt_r;
   logic [3:0]  evt_clr_s;
   logic [3:0]  evt_next_s;
   logic [31:0] timer_rd_s;
   logic        unused_bits_s;

   assign wr_s = bus.sel & bus.memwrite;

   // Address and data bits that no register decodes.
   assign unused_bits_s = ^{bus.addr[31:8], bus.addr[1:0],
                            bus.writedata[31:24], bus.writemask[3]};

   for (genvar g = 0; g < 4; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .clk     (clk),
         .reset   (reset),
         .key_raw (KEY[g]),
         .key_db  (key_db_s[g]),
         .press   (press_s[g])
      );
   end

   // Next values for the writable registers; several selects may hit at once.
   always_comb begin
      led_next_s = led_r;
      hex_next_s = hex_r;
      evt_clr_s  = 4'd0;
      if (wr_s && bus.addr[IO_LEDS_bit]) begin
         led_next_s[7:0] = lane_pick(led_r[7:0], bus.writedata[7:0], bus.writemask[0]);
         if (bus.writemask[1]) begin
            led_next_s[9:8] = bus.writedata[9:8];
         end else begin
            led_next_s[9:8] = led_r[9:8];
         end
      end else begin
         led_next_s = led_r;
      end
      if (wr_s && bus.addr[IO_HEX_bit]) begin
         hex_next_s[7:0]   = lane_pick(hex_r[7:0],   bus.writedata[7:0],   bus.writemask[0]);
         hex_next_s[15:8]  = lane_pick(hex_r[15:8],  bus.writedata[15:8],  bus.writemask[1]);
         hex_next_s[23:16] = lane_pick(hex_r[23:16], bus.writedata[23:16], bus.writemask[2]);
      end else begin
         hex_next_s = hex_r;
      end
      if (wr_s && bus.addr[IO_KEYEVT_bit] && bus.writemask[0]) begin
         evt_clr_s = bus.writedata[3:0];
      end else begin
         evt_clr_s = 4'd0;
      end
      // Set after clear so a press coinciding with its clear is kept.
      evt_next_s = (evt_r & ~evt_clr_s) | press_s;
   end

   // LED, HEX, event and switch-synchronizer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_r      <= 10'd0;
         hex_r      <= 24'd0;
         evt_r      <= 4'd0;
         sw_sync1_r <= 10'd0;
         sw_sync2_r <= 10'd0;
      end else begin
         led_r      <= led_next_s;
         hex_r      <= hex_next_s;
         evt_r      <= evt_next_s;
         sw_sync1_r <= SW;
         sw_sync2_r <= sw_sync1_r;
      end
   end

`ifdef IO_TIMER_EN
   logic [31:0] timer_r;
   logic [31:0] timer_inc_s;
   logic [31:0] timer_next_s;

   // Written lanes take the store data, the rest keep the incremented count.
   always_comb begin
      timer_inc_s  = timer_r + 32'd1;
      timer_next_s = timer_inc_s;
      if (wr_s && bus.addr[IO_TIMER_bit]) begin
         for (int i = 0; i < 4; i++) begin
            timer_next_s[8*i +: 8] = lane_pick(timer_inc_s[8*i +: 8],
                                               bus.writedata[8*i +: 8],
                                               bus.writemask[i]);
         end
      end else begin
         timer_next_s = timer_inc_s;
      end
   end

   // Free-running timer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_r <= 32'd0;
      end else begin
         timer_r <= timer_next_s;
      end
   end

   assign timer_rd_s = timer_r;
`else
   assign timer_rd_s = 32'd0;
`endif

   // Load mux: the lowest set select bit wins; reads never change state.
   always_comb begin
      bus.readdata = 32'd0;
      if (!bus.sel) begin
         bus.readdata = 32'd0;
      end else if (bus.addr[IO_LEDS_bit]) begin
         bus.readdata = {22'd0, led_r};
      end else if (bus.addr[IO_HEX_bit]) begin
         bus.readdata = {8'd0, hex_r};
      end else if (bus.addr[IO_KEY_bit]) begin
         bus.readdata = {28'd0, key_db_s};
      end else if (bus.addr[IO_SW_bit]) begin
         bus.readdata = {22'd0, sw_sync2_r};
      end else if (bus.addr[IO_KEYEVT_bit]) begin
         bus.readdata = {28'd0, evt_r};
      end else if (bus.addr[IO_TIMER_bit]) begin
         bus.readdata = timer_rd_s;
      end else begin
         bus.readdata = 32'd0;
      end
   end

   assign LEDR       = led_r;
   assign hex_digits = hex_r;

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: the number of consecutive stable synchronized samples needed to accept a key change (legal range 1..255).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port sel, input, 1 bit: the CPU data access targets the I/O region.
REQ-005 The block SHALL have the port addr, input, 32 bits: the CPU data address; one-hot device select in bits [7:2].
REQ-006 The block SHALL have the port writedata, input, 32 bits: the CPU store data.
REQ-007 The block SHALL have the port memwrite, input, 1 bit: a store strobe, one cycle per store.
REQ-008 The block SHALL have the port writemask, input, 4 bits: per-byte write enables (bit n covers byte n).
REQ-009 The block SHALL have the port readdata, output, 32 bits: combinational load data.
REQ-010 The block SHALL have the port KEY, input, 4 bits: raw asynchronous push-buttons, active-low.
REQ-011 The block SHALL have the port SW, input, 10 bits: raw slide switches.
REQ-012 The block SHALL have the port LEDR, output, 10 bits: the registered LED value.
REQ-013 The block SHALL have the port hex_digits, output, 24 bits: the registered six-nibble display value.

Function
REQ-014 Address map (one-hot bits): LED 0x104 (bit 2), HEX 0x108 (bit 3), KEY 0x110 (bit 4), SW 0x120 (bit 5), KEYEVT 0x140 (bit 6), TIMER 0x180 (bit 7).
REQ-015 Write = sel & memwrite; every register whose bit is set in addr SHALL be written in the same cycle, honouring writemask per byte lane.
REQ-016 LED write: LEDR[7:0] SHALL update when writemask[0] is set; LEDR[9:8] SHALL update when writemask[1] is set.
REQ-017 HEX write: hex_digits byte n SHALL update when writemask[n] is set (n = 0..2); writemask[3] SHALL be ignored.
REQ-018 readdata SHALL be 0 when sel=0; otherwise the lowest set address bit in [7:2] selects the source; no bit set SHALL return 0.
REQ-019 Read values: LED {22'b0, LEDR}; HEX {8'b0, hex_digits}; KEY {28'b0, key_db}; SW {22'b0, sw_sync}; KEYEVT {28'b0, evt}; TIMER the counter value.
REQ-020 KEY and SW SHALL each pass through a 2-flop synchronizer before any use.
REQ-021 Debounce, per key: when sync equals key_db, the counter SHALL clear; otherwise it SHALL increment, and on the cycle it equals DEBOUNCE_CYCLES-1, key_db SHALL take sync and the counter SHALL clear.
REQ-022 Debounce latency from a raw KEY edge to the key_db change SHALL be 2+DEBOUNCE_CYCLES cycles; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change key_db.
REQ-023 Press event: evt[i] SHALL set on the edge where key_db[i] goes 1 to 0 (release SHALL NOT set it), and SHALL be sticky.
REQ-024 KEYEVT write with writemask[0]: write-1-to-clear on writedata[3:0]; a simultaneous set and clear of the same bit SHALL leave it set.
REQ-025 Reads SHALL have no side effects.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL set: LEDR=0, hex_digits=0, evt=0, timer=0, debounce counters=0, KEY synchronizer and key_db=4'hF, SW synchronizer=0.
REQ-027 Reset SHALL override any write in the same cycle; a debounce in progress SHALL be discarded, and no event SHALL fire from the reset value.

Configuration
REQ-028 Macro IO_TIMER_EN defined: a 32-bit free-running counter SHALL increment every cycle and wrap 0xFFFFFFFF to 0; a TIMER write SHALL load it per byte lane, and masked bytes SHALL keep their incremented value; the write SHALL win over the increment.
REQ-029 Macro IO_TIMER_EN undefined: the counter logic SHALL be absent, a TIMER read SHALL return 0, and a TIMER write SHALL be ignored.

Structure
REQ-030 Package io_pkg SHALL hold the address-bit localparams (IO_LEDS_bit..IO_TIMER_bit), the KEY reset constant 4'hF and the DEBOUNCE_CYCLES default.
REQ-031 Sub-module key_debounce SHALL hold one synchronizer, counter and debounced bit, with parameter DEBOUNCE_CYCLES; it SHALL be instantiated four times.

Verification
REQ-032 Scenario: store 0x3FF to 0x104 with mask 4'b0001 -> LEDR=0x0FF; then store 0x300 with mask 4'b0010 -> LEDR=0x3FF; load 0x104 -> 0x3FF.
REQ-033 Scenario: store 0xABCDEF to 0x108 with mask 4'b0101 -> hex_digits=0xAB00EF; store to 0x10C (bits 2 and 3) -> LEDR and hex_digits both updated.
REQ-034 Scenario: KEY[1] held low continuously with DEBOUNCE_CYCLES=4 -> key_db[1]=0 exactly 6 cycles after the edge, evt=4'b0010; a 3-cycle low glitch on KEY[2] -> no change.
REQ-035 Scenario: evt=4'b0011, store 0x1 to 0x140 -> evt=4'b0010; a press completing on KEY[0] in the same cycle as its clear -> evt[0] stays 1.
REQ-036 Scenario (IO_TIMER_EN): store 0xFFFFFFFE to 0x180 -> reads 0xFFFFFFFF then 0 on the next two cycles; undefined -> reads 0.
REQ-037 Scenario: reset asserted mid-debounce with outputs nonzero -> all REQ-026 values next cycle, and no event after release.
